jelly_fifo_ra_checked: RTL and testbench
========================================

// Module: jelly_fifo_ra_checked
// PURPOSE
//  Random-access FIFO with explicit pointer management and guarded pointer updates.
//  Producer/consumer write and read RAM at arbitrary addresses, then publish new pointers.
//  Updates that would overflow or underflow the FIFO are rejected and logged in sticky error flags.
//  Reports true empty state after reset, plus programmable almost-full/almost-empty flags.
// PARAMETERS
//  DATA_WIDTH       8        RAM word width
//  ADDR_WIDTH       9        RAM address width; SIZE = 2**ADDR_WIDTH words
//  DOUT_REGS        1        0/1: extra RAM output register (read latency 1+DOUT_REGS)
//  RAM_TYPE         "block"  passed to RAM primitive
//  ALMOST_FULL_TH   SIZE-1   almost_full when data_count >= this
//  ALMOST_EMPTY_TH  1        almost_empty when data_count <= this
//  (localparam PTR_WIDTH = ADDR_WIDTH+1; all pointers/counts PTR_WIDTH bits)
// PORTS
//  reset_n          in   1           async active-low reset
//  clk              in   1           single clock
//  wr_en            in   1           RAM write port enable
//  wr_we            in   1           write strobe; RAM written only when wr_en&&wr_we
//  wr_addr          in   ADDR_WIDTH  write address;  wr_data  in  DATA_WIDTH
//  wr_ptr_next      in   PTR_WIDTH   proposed write pointer;  wr_ptr_update  in  1
//  wr_ptr           out  PTR_WIDTH   committed write pointer
//  rd_en/rd_regcke  in   1           RAM read enable / output-register clock enable
//  rd_addr          in   ADDR_WIDTH  read address;  rd_data  out  DATA_WIDTH
//  rd_ptr_next      in   PTR_WIDTH   proposed read pointer;  rd_ptr_update  in  1
//  rd_ptr           out  PTR_WIDTH   committed read pointer
//  full, empty, almost_full, almost_empty  out  1  registered status
//  free_count, data_count                   out  PTR_WIDTH  registered counts
//  next_full, next_empty, next_free_count, next_data_count  out  comb. values to be registered next edge
//  err_clear        in   1           clears sticky error flags
//  err_overflow     out  1           sticky: write update rejected
//  err_underflow    out  1           sticky: read update rejected
// BEHAVIOUR
//  Reset (async assert, sync release): pointers=0, empty=1, full=0, data_count=0,
//   free_count=SIZE, almost_empty=(0<=ALMOST_EMPTY_TH), almost_full=0, errors=0.
//  Write accept: wr_ptr_update && (wr_ptr_next-wr_ptr) mod 2**PTR_WIDTH <= free_count.
//  Read accept:  rd_ptr_update && (rd_ptr_next-rd_ptr) mod 2**PTR_WIDTH <= data_count.
//  Each check uses only registered values of the opposite pointer (conservative);
//   simultaneous accepted updates both apply on the same edge.
//  Rejected update: pointer holds, matching error flag set next edge; other side unaffected.
//  Pointers update one edge after accepted request; counts/flags updated on the same edge.
//  data_count=nwr-nrd; free_count=SIZE-data_count; empty=(nwr==nrd);
//   full=(MSBs differ && lower ADDR_WIDTH bits equal); all mod 2**PTR_WIDTH.
//  Sticky errors: err_clear wins over new set in same cycle? No: set wins (error not lost).
//  RAM: write is fire-and-forget; rd_data valid 1+DOUT_REGS cycles after rd_en (regcke gated).
//  RAM contents are not cleared by reset; no read/write address collision protection.
//  next_* are combinational from current registers + accepted updates (zero-cycle look-ahead).
// STRUCTURE
//  Instantiates jelly_ram_simple_dualport for storage (no new RAM sub-module).
//  Pointer/count/flag logic in one always @* plus one async-reset always block.
//  No shared package; PTR_WIDTH/SIZE are local params.
//  Pointer-distance helper may be a local function.
// TESTING (ADDR_WIDTH=4, SIZE=16, DOUT_REGS=1, DATA_WIDTH=8)
//  Reset low mid-traffic -> all outputs reset values immediately; free_count=16, empty=1, full=0.
//  Write 0..15 to addr 0..15, wr_ptr_next=16 -> next edge full=1, data_count=16, almost_full=1.
//  Read addr 3 with rd_en, rd_regcke=1 -> rd_data=3 two cycles later; rd_ptr_next=4 -> data_count=12.
//  With data_count=12, wr_ptr_next=wr_ptr+5 -> rejected, wr_ptr holds, err_overflow=1 until err_clear.
//  With data_count=2, rd_ptr_next=rd_ptr+3 together with a valid wr +4 -> read rejected (err_underflow=1),
//   write accepted, data_count=6.
//  Wrap: run 40 write/read pairs of 7 words -> pointers wrap past 31 -> counts stay correct,
//   empty asserts after each drain.

Source files
------------

// File: rtl/jelly_ram_simple_dualport.sv
// Simple dual-port RAM: one write port, one registered read port with an
// optional second output register gated by rd_regcke.
module jelly_ram_simple_dualport #(
  parameter int ADDR_WIDTH = 9,
  parameter int DATA_WIDTH = 8,
  parameter     RAM_TYPE   = "block",
  parameter int DOUT_REGS  = 1
) (
  input  logic                  clk,
  input  logic                  wr_en,
  input  logic [ADDR_WIDTH-1:0] wr_addr,
  input  logic [DATA_WIDTH-1:0] wr_din,
  input  logic                  rd_en,
  input  logic                  rd_regcke,
  input  logic [ADDR_WIDTH-1:0] rd_addr,
  output logic [DATA_WIDTH-1:0] rd_dout
);

  (* ram_style = RAM_TYPE *) logic [DATA_WIDTH-1:0] mem [0:(1 << ADDR_WIDTH)-1];
  logic [DATA_WIDTH-1:0] rd_q_p0;

  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem[wr_addr] <= wr_din;
    end
  end

  // stage p0: synchronous array read
  always_ff @(posedge clk) begin
    if (rd_en) begin
      rd_q_p0 <= mem[rd_addr];
    end
  end

  generate
    if (DOUT_REGS != 0) begin : g_dout_reg
      logic [DATA_WIDTH-1:0] rd_q_p1;
      // stage p1: optional output register
      always_ff @(posedge clk) begin
        if (rd_regcke) begin
          rd_q_p1 <= rd_q_p0;
        end
      end
      assign rd_dout = rd_q_p1;
    end else begin : g_dout_direct
      logic unused_regcke;
      assign unused_regcke = rd_regcke;
      assign rd_dout       = rd_q_p0;
    end
  endgenerate

endmodule

// File: rtl/jelly_fifo_ra_checked.sv
// Random-access FIFO: RAM accessed at arbitrary addresses, pointers published
// explicitly and rejected when they would overflow or underflow the buffer.
module jelly_fifo_ra_checked #(
  parameter int  DATA_WIDTH      = 8,
  parameter int  ADDR_WIDTH      = 9,
  parameter int  DOUT_REGS       = 1,
  parameter      RAM_TYPE        = "block",
  parameter int  ALMOST_FULL_TH  = (1 << ADDR_WIDTH) - 1,
  parameter int  ALMOST_EMPTY_TH = 1,
  localparam int PTR_WIDTH       = ADDR_WIDTH + 1
) (
  input  logic                  reset_n,
  input  logic                  clk,

  input  logic                  wr_en,
  input  logic                  wr_we,
  input  logic [ADDR_WIDTH-1:0] wr_addr,
  input  logic [DATA_WIDTH-1:0] wr_data,
  input  logic [PTR_WIDTH-1:0]  wr_ptr_next,
  input  logic                  wr_ptr_update,
  output logic [PTR_WIDTH-1:0]  wr_ptr,

  input  logic                  rd_en,
  input  logic                  rd_regcke,
  input  logic [ADDR_WIDTH-1:0] rd_addr,
  output logic [DATA_WIDTH-1:0] rd_data,
  input  logic [PTR_WIDTH-1:0]  rd_ptr_next,
  input  logic                  rd_ptr_update,
  output logic [PTR_WIDTH-1:0]  rd_ptr,

  output logic                  full,
  output logic                  empty,
  output logic                  almost_full,
  output logic                  almost_empty,
  output logic [PTR_WIDTH-1:0]  free_count,
  output logic [PTR_WIDTH-1:0]  data_count,

  output logic                  next_full,
  output logic                  next_empty,
  output logic [PTR_WIDTH-1:0]  next_free_count,
  output logic [PTR_WIDTH-1:0]  next_data_count,

  input  logic                  err_clear,
  output logic                  err_overflow,
  output logic                  err_underflow
);

  localparam logic [PTR_WIDTH-1:0] SIZE     = PTR_WIDTH'(1 << ADDR_WIDTH);
  localparam logic [PTR_WIDTH-1:0] AF_TH    = PTR_WIDTH'(ALMOST_FULL_TH);
  localparam logic [PTR_WIDTH-1:0] AE_TH    = PTR_WIDTH'(ALMOST_EMPTY_TH);
  localparam logic                 AE_RESET = (ALMOST_EMPTY_TH >= 0);

  function automatic logic [PTR_WIDTH-1:0] ptr_dist(input logic [PTR_WIDTH-1:0] to_ptr,
                                                    input logic [PTR_WIDTH-1:0] from_ptr);
    return to_ptr - from_ptr;
  endfunction

  jelly_ram_simple_dualport #(
    .ADDR_WIDTH (ADDR_WIDTH),
    .DATA_WIDTH (DATA_WIDTH),
    .RAM_TYPE   (RAM_TYPE),
    .DOUT_REGS  (DOUT_REGS)
  ) u_ram (
    .clk       (clk),
    .wr_en     (wr_en & wr_we),
    .wr_addr   (wr_addr),
    .wr_din    (wr_data),
    .rd_en     (rd_en),
    .rd_regcke (rd_regcke),
    .rd_addr   (rd_addr),
    .rd_dout   (rd_data)
  );

  logic                 wr_accept;
  logic                 rd_accept;
  logic [PTR_WIDTH-1:0] next_wr_ptr;
  logic [PTR_WIDTH-1:0] next_rd_ptr;
  logic                 next_almost_full;
  logic                 next_almost_empty;
  logic                 next_err_overflow;
  logic                 next_err_underflow;

  // Each side is checked against the registered counts only, so a write never
  // counts on space freed by a read landing on the same edge (and vice versa).
  always_comb begin
    wr_accept          = wr_ptr_update && (ptr_dist(wr_ptr_next, wr_ptr) <= free_count);
    rd_accept          = rd_ptr_update && (ptr_dist(rd_ptr_next, rd_ptr) <= data_count);
    next_wr_ptr        = wr_accept ? wr_ptr_next : wr_ptr;
    next_rd_ptr        = rd_accept ? rd_ptr_next : rd_ptr;
    next_data_count    = ptr_dist(next_wr_ptr, next_rd_ptr);
    next_free_count    = SIZE - next_data_count;
    next_empty         = (next_wr_ptr == next_rd_ptr);
    next_full          = (next_wr_ptr[PTR_WIDTH-1] != next_rd_ptr[PTR_WIDTH-1]) &&
                         (next_wr_ptr[ADDR_WIDTH-1:0] == next_rd_ptr[ADDR_WIDTH-1:0]);
    next_almost_full   = (next_data_count >= AF_TH);
    next_almost_empty  = (next_data_count <= AE_TH);
    // a new rejection wins over err_clear so no error is silently lost
    next_err_overflow  = (err_overflow  && !err_clear) || (wr_ptr_update && !wr_accept);
    next_err_underflow = (err_underflow && !err_clear) || (rd_ptr_update && !rd_accept);
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr        <= '0;
      rd_ptr        <= '0;
      full          <= 1'b0;
      empty         <= 1'b1;
      almost_full   <= 1'b0;
      almost_empty  <= AE_RESET;
      free_count    <= SIZE;
      data_count    <= '0;
      err_overflow  <= 1'b0;
      err_underflow <= 1'b0;
    end else begin
      wr_ptr        <= next_wr_ptr;
      rd_ptr        <= next_rd_ptr;
      full          <= next_full;
      empty         <= next_empty;
      almost_full   <= next_almost_full;
      almost_empty  <= next_almost_empty;
      free_count    <= next_free_count;
      data_count    <= next_data_count;
      err_overflow  <= next_err_overflow;
      err_underflow <= next_err_underflow;
    end
  end

endmodule

// File: tb/tb_jelly_fifo_ra_checked.sv
// Randomised bench for jelly_fifo_ra_checked (16-word FIFO) with a queue-based
// occupancy/RAM model compared every cycle, plus directed literal checks.
module tb_jelly_fifo_ra_checked;

  localparam int AW = 4;
  localparam int DW = 8;
  localparam int PW = AW + 1;
  localparam int SZ = 16;

  logic          reset_n;
  logic          clk;
  logic          wr_en, wr_we, wr_ptr_update;
  logic [AW-1:0] wr_addr;
  logic [DW-1:0] wr_data;
  logic [PW-1:0] wr_ptr_next, wr_ptr;
  logic          rd_en, rd_regcke, rd_ptr_update;
  logic [AW-1:0] rd_addr;
  logic [DW-1:0] rd_data;
  logic [PW-1:0] rd_ptr_next, rd_ptr;
  logic          full, empty, almost_full, almost_empty;
  logic [PW-1:0] free_count, data_count;
  logic          next_full, next_empty;
  logic [PW-1:0] next_free_count, next_data_count;
  logic          err_clear, err_overflow, err_underflow;

  jelly_fifo_ra_checked #(
    .DATA_WIDTH (DW),
    .ADDR_WIDTH (AW),
    .DOUT_REGS  (1)
  ) dut (
    .reset_n         (reset_n),
    .clk             (clk),
    .wr_en           (wr_en),
    .wr_we           (wr_we),
    .wr_addr         (wr_addr),
    .wr_data         (wr_data),
    .wr_ptr_next     (wr_ptr_next),
    .wr_ptr_update   (wr_ptr_update),
    .wr_ptr          (wr_ptr),
    .rd_en           (rd_en),
    .rd_regcke       (rd_regcke),
    .rd_addr         (rd_addr),
    .rd_data         (rd_data),
    .rd_ptr_next     (rd_ptr_next),
    .rd_ptr_update   (rd_ptr_update),
    .rd_ptr          (rd_ptr),
    .full            (full),
    .empty           (empty),
    .almost_full     (almost_full),
    .almost_empty    (almost_empty),
    .free_count      (free_count),
    .data_count      (data_count),
    .next_full       (next_full),
    .next_empty      (next_empty),
    .next_free_count (next_free_count),
    .next_data_count (next_data_count),
    .err_clear       (err_clear),
    .err_overflow    (err_overflow),
    .err_underflow   (err_underflow)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_cmp  = 0;
  int n_fail = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Behavioural model: pointers as plain integers mod 32, RAM as an array,
  // pending reads as a queue of (due cycle, expected word).
  typedef struct {
    int          due;
    logic [7:0]  val;
  } rd_exp_t;

  int         m_wr, m_rd, m_eo, m_eu, cyc;
  logic [7:0] m_mem [SZ];
  rd_exp_t    rdq [$];

  function automatic void predict(output int nwr, output int nrd, output int neo, output int neu);
    int dc, wd, rdist;
    bit wacc, racc;
    dc    = (m_wr - m_rd) & 31;
    wd    = (int'(wr_ptr_next) - m_wr) & 31;
    rdist = (int'(rd_ptr_next) - m_rd) & 31;
    wacc  = wr_ptr_update && (wd <= SZ - dc);
    racc  = rd_ptr_update && (rdist <= dc);
    nwr   = wacc ? int'(wr_ptr_next) : m_wr;
    nrd   = racc ? int'(rd_ptr_next) : m_rd;
    neo   = (wr_ptr_update && !wacc) ? 1 : (err_clear ? 0 : m_eo);
    neu   = (rd_ptr_update && !racc) ? 1 : (err_clear ? 0 : m_eu);
  endfunction

  always @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      m_wr <= 0;
      m_rd <= 0;
      m_eo <= 0;
      m_eu <= 0;
      rdq.delete();
    end else begin
      int nwr, nrd, neo, neu;
      rd_exp_t e;
      predict(nwr, nrd, neo, neu);
      if (rd_en) begin
        e.due = cyc + 2;
        e.val = m_mem[rd_addr];
        rdq.push_back(e);
      end
      if (wr_en && wr_we) m_mem[wr_addr] <= wr_data;
      m_wr <= nwr;
      m_rd <= nrd;
      m_eo <= neo;
      m_eu <= neu;
      cyc  <= cyc + 1;
    end
  end

  always @(negedge clk) begin
    int dc, nwr, nrd, neo, neu, ndc;
    dc = (m_wr - m_rd) & 31;
    check("wr_ptr",        wr_ptr,        m_wr);
    check("rd_ptr",        rd_ptr,        m_rd);
    check("data_count",    data_count,    dc);
    check("free_count",    free_count,    SZ - dc);
    check("empty",         empty,         dc == 0);
    check("full",          full,          dc == SZ);
    check("almost_full",   almost_full,   dc >= SZ - 1);
    check("almost_empty",  almost_empty,  dc <= 1);
    check("err_overflow",  err_overflow,  m_eo);
    check("err_underflow", err_underflow, m_eu);
    predict(nwr, nrd, neo, neu);
    ndc = (nwr - nrd) & 31;
    check("next_data_count", next_data_count, ndc);
    check("next_free_count", next_free_count, SZ - ndc);
    check("next_empty",      next_empty,      ndc == 0);
    check("next_full",       next_full,       ndc == SZ);
    while (rdq.size() > 0 && rdq[0].due < cyc) void'(rdq.pop_front());
    if (rdq.size() > 0 && rdq[0].due == cyc) begin
      check("rd_data", rd_data, rdq[0].val);
      void'(rdq.pop_front());
    end
  end

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic idle();
    wr_en = 0; wr_we = 0; wr_ptr_update = 0;
    rd_en = 0; rd_ptr_update = 0; err_clear = 0;
  endtask

  task automatic rand_inputs();
    wr_en         = 1'($urandom);
    wr_we         = ($urandom % 4) != 0;
    wr_addr       = AW'($urandom);
    wr_data       = DW'($urandom);
    wr_ptr_update = ($urandom % 3) == 0;
    wr_ptr_next   = ($urandom % 16 == 0) ? PW'($urandom) : PW'(m_wr + $urandom_range(0, 9));
    rd_en         = 1'($urandom);
    rd_addr       = AW'($urandom);
    if (wr_en && wr_we && rd_en && rd_addr == wr_addr) rd_addr = wr_addr + 1'b1;
    rd_ptr_update = ($urandom % 3) == 0;
    rd_ptr_next   = ($urandom % 16 == 0) ? PW'($urandom) : PW'(m_rd + $urandom_range(0, 9));
    err_clear     = ($urandom % 10) == 0;
  endtask

  initial begin
    int wp, rp;
    cyc = 0;
    wr_addr = '0; wr_data = '0; wr_ptr_next = '0;
    rd_addr = '0; rd_ptr_next = '0; rd_regcke = 1'b1;
    idle();
    reset_n = 1'b1;
    #1 reset_n = 1'b0;
    repeat (3) @(posedge clk);
    #2 reset_n = 1'b1;

    check("rst_free_count",   free_count,   16);
    check("rst_empty",        empty,        1);
    check("rst_full",         full,         0);
    check("rst_almost_empty", almost_empty, 1);

    for (int i = 0; i < 16; i++) begin
      wr_en = 1; wr_we = 1; wr_addr = AW'(i); wr_data = DW'(i);
      tick();
    end
    idle();
    wr_ptr_next = 5'd16; wr_ptr_update = 1;
    tick();
    idle();
    check("fill_full",        full,        1);
    check("fill_data_count",  data_count,  16);
    check("fill_almost_full", almost_full, 1);
    check("fill_free_count",  free_count,  0);

    rd_en = 1; rd_addr = 4'd3;
    tick();
    idle();
    tick();
    check("read_addr3", rd_data, 3);
    rd_ptr_next = 5'd4; rd_ptr_update = 1;
    tick();
    idle();
    check("read_data_count", data_count, 12);

    wr_ptr_next = 5'd21; wr_ptr_update = 1;
    tick();
    idle();
    check("ovf_wr_ptr_hold", wr_ptr,       16);
    check("ovf_flag",        err_overflow, 1);
    tick(); tick();
    check("ovf_sticky",      err_overflow, 1);
    err_clear = 1;
    tick();
    idle();
    check("ovf_cleared",     err_overflow, 0);
    wr_ptr_next = 5'd21; wr_ptr_update = 1; err_clear = 1;
    tick();
    idle();
    check("ovf_set_beats_clear", err_overflow, 1);
    err_clear = 1;
    tick();
    idle();

    rd_ptr_next = 5'd14; rd_ptr_update = 1;
    tick();
    idle();
    check("udf_pre_count", data_count, 2);
    rd_ptr_next = 5'd17; rd_ptr_update = 1;
    wr_ptr_next = 5'd20; wr_ptr_update = 1;
    tick();
    idle();
    check("udf_flag",       err_underflow, 1);
    check("udf_no_ovf",     err_overflow,  0);
    check("udf_rd_hold",    rd_ptr,        14);
    check("udf_wr_applied", wr_ptr,        20);
    check("udf_data_count", data_count,    6);
    err_clear = 1; rd_ptr_next = 5'd20; rd_ptr_update = 1;
    tick();
    idle();
    check("drain_empty", empty, 1);

    wp = 20; rp = 20;
    for (int k = 0; k < 40; k++) begin
      for (int i = 0; i < 7; i++) begin
        wr_en = 1; wr_we = 1; wr_addr = AW'(wp + i); wr_data = DW'($urandom);
        tick();
      end
      idle();
      wp = (wp + 7) & 31;
      wr_ptr_next = PW'(wp); wr_ptr_update = 1;
      tick();
      idle();
      check("wrap_filled", data_count, 7);
      for (int i = 0; i < 7; i++) begin
        rd_en = 1; rd_addr = AW'(rp + i);
        tick();
      end
      idle();
      rp = (rp + 7) & 31;
      rd_ptr_next = PW'(rp); rd_ptr_update = 1;
      tick();
      idle();
      check("wrap_empty",  empty,  1);
      check("wrap_rd_ptr", rd_ptr, rp);
    end

    for (int n = 0; n < 2000; n++) begin
      if (n == 700) begin
        #1 reset_n = 1'b0;
        #1;
        check("midrst_free_count", free_count, 16);
        check("midrst_empty",      empty,      1);
        check("midrst_full",       full,       0);
        check("midrst_data_count", data_count, 0);
        check("midrst_wr_ptr",     wr_ptr,     0);
        check("midrst_err",        {err_overflow, err_underflow}, 0);
        tick(); tick();
        reset_n = 1'b1;
      end
      rand_inputs();
      tick();
    end
    idle();
    tick(); tick(); tick();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
